// File: rtl/memory_arbiter_pkg.sv
// Shared command/requester encodings and arbiter state type for the memory port arbiter.
// The controller's memory_command encoding uses MEM_READ/MEM_WRITE from here.
package memory_arbiter_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter for the single memory port; one transaction
// outstanding at a time, with the completion routed back to the owning requester.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_enable,
    input  logic [NUM_REQ-1:0]                   req_command,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_address,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   req_valid,
    output logic [DATA_WIDTH-1:0]                req_rdata,
    output logic                                 mem_enable,
    output logic                                 mem_command,
    output logic [ADDR_WIDTH-1:0]                mem_address,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    output logic [STRB_WIDTH-1:0]                mem_wstrb,
    input  logic                                 mem_ready,
    input  logic                                 mem_valid,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    output logic [1:0]                           owner
);

    arb_state_t state_reg, state_next;
    logic       turn_reg, turn_next;
    logic       owner_reg, owner_next;
    logic       idle;

    assign idle = (state_reg == ST_IDLE);

    // Ready depends only on state, turn and mem_ready, never on req_enable,
    // so no combinational loop exists through a requester's handshake logic.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign req_ready[gi] = ~reset & idle & mem_ready & (turn_reg == 1'(gi));
            assign req_valid[gi] = ~reset & ~idle & mem_valid & (owner_reg == 1'(gi));
        end
    endgenerate

    assign mem_enable  = req_enable[turn_reg] & req_ready[turn_reg];
    assign mem_command = mem_enable & req_command[turn_reg];
    assign mem_address = req_address[turn_reg];
    assign mem_wdata   = req_wdata[turn_reg];
    assign mem_wstrb   = req_wstrb[turn_reg];
    assign req_rdata   = mem_rdata;
    assign owner       = idle ? 2'b00 : {1'b1, owner_reg};

    always_comb begin
        state_next = state_reg;
        turn_next  = turn_reg;
        owner_next = owner_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_enable) begin
                    state_next = ST_BUSY;
                    owner_next = turn_reg;
                end else if (mem_ready && !req_enable[turn_reg]) begin
                    // Park flip: an idle turn holder gives the slot away.
                    turn_next = other_req(turn_reg);
                end
            end
            ST_BUSY: begin
                if (mem_valid) begin
                    state_next = ST_IDLE;
                    turn_next  = other_req(owner_reg);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            turn_reg  <= REQ_CORE;
            owner_reg <= REQ_CORE;
        end else begin
            state_reg <= state_next;
            turn_reg  <= turn_next;
            owner_reg <= owner_next;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Table-driven bench for memory_arbiter: one record per clock cycle holding the
// inputs for that cycle and the outputs expected before the next edge.
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    localparam logic [DW-1:0] P0_WDATA = 32'hCAFE0000;
    localparam logic [SW-1:0] P0_WSTRB = 4'hF;
    localparam logic [DW-1:0] P1_WDATA = 32'h00000055;
    localparam logic [SW-1:0] P1_WSTRB = 4'h1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [1:0]            req_enable;
    logic [1:0]            req_command;
    logic [1:0][AW-1:0]    req_address;
    logic [1:0][DW-1:0]    req_wdata;
    logic [1:0][SW-1:0]    req_wstrb;
    logic [1:0]            req_ready;
    logic [1:0]            req_valid;
    logic [DW-1:0]         req_rdata;
    logic                  mem_enable;
    logic                  mem_command;
    logic [AW-1:0]         mem_address;
    logic [DW-1:0]         mem_wdata;
    logic [SW-1:0]         mem_wstrb;
    logic                  mem_ready;
    logic                  mem_valid;
    logic [DW-1:0]         mem_rdata;
    logic [1:0]            owner;

    memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .req_enable(req_enable), .req_command(req_command), .req_address(req_address),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ready(req_ready), .req_valid(req_valid), .req_rdata(req_rdata),
        .mem_enable(mem_enable), .mem_command(mem_command), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    typedef struct {
        logic          rst;
        logic [1:0]    en;
        logic          mr;
        logic          mv;
        logic [DW-1:0] rdata;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    xr;
        logic [1:0]    xv;
        logic          xm;
        logic [AW-1:0] xaddr;
        logic          xcmd;
        logic [1:0]    xown;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;

    task automatic add(input logic rst, input logic [1:0] en, input logic mr, input logic mv,
                       input logic [DW-1:0] rd, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [1:0] xr, input logic [1:0] xv, input logic xm,
                       input logic [AW-1:0] xaddr, input logic xcmd, input logic [1:0] xown);
        vec_t v;
        v.rst = rst; v.en = en; v.mr = mr; v.mv = mv; v.rdata = rd; v.a0 = a0; v.a1 = a1;
        v.xr = xr; v.xv = xv; v.xm = xm; v.xaddr = xaddr; v.xcmd = xcmd; v.xown = xown;
        vecs.push_back(v);
    endtask

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL vec %0d %s: got 0x%0h, expected 0x%0h", idx, name, act, exp);
        end
    endtask

    initial begin
        // A: reset, then port0 read at 0x100 answered three cycles later
        add(1, 2'b00, 1, 0, 0,            32'h100, 32'h20, 2'b00, 2'b00, 0, 0,       0, 2'b00);
        add(0, 2'b01, 1, 0, 0,            32'h100, 32'h20, 2'b01, 2'b00, 1, 32'h100, 0, 2'b00);
        add(0, 2'b00, 1, 0, 0,            32'h100, 32'h20, 2'b00, 2'b00, 0, 0,       0, 2'b10);
        add(0, 2'b00, 1, 0, 0,            32'h100, 32'h20, 2'b00, 2'b00, 0, 0,       0, 2'b10);
        add(0, 2'b00, 1, 1, 32'hDEADBEEF, 32'h100, 32'h20, 2'b00, 2'b01, 0, 0,       0, 2'b10);
        // B: both ports request continuously, grants alternate 0,1,0,1
        add(1, 2'b11, 1, 0, 0,            32'h10, 32'h20, 2'b00, 2'b00, 0, 0,      0, 2'b00);
        add(0, 2'b11, 1, 0, 0,            32'h10, 32'h20, 2'b01, 2'b00, 1, 32'h10, 0, 2'b00);
        add(0, 2'b11, 1, 1, 32'h11111111, 32'h10, 32'h20, 2'b00, 2'b01, 0, 0,      0, 2'b10);
        add(0, 2'b11, 1, 0, 0,            32'h10, 32'h20, 2'b10, 2'b00, 1, 32'h20, 1, 2'b00);
        add(0, 2'b11, 1, 1, 0,            32'h10, 32'h20, 2'b00, 2'b10, 0, 0,      0, 2'b11);
        add(0, 2'b11, 1, 0, 0,            32'h10, 32'h20, 2'b01, 2'b00, 1, 32'h10, 0, 2'b00);
        add(0, 2'b11, 1, 1, 32'h22222222, 32'h10, 32'h20, 2'b00, 2'b01, 0, 0,      0, 2'b10);
        add(0, 2'b11, 1, 0, 0,            32'h10, 32'h20, 2'b10, 2'b00, 1, 32'h20, 1, 2'b00);
        add(0, 2'b11, 1, 1, 0,            32'h10, 32'h20, 2'b00, 2'b10, 0, 0,      0, 2'b11);
        // C: only port1 requests from reset release; park flip then grant
        add(1, 2'b10, 1, 0, 0, 32'h100, 32'h20, 2'b00, 2'b00, 0, 0,      0, 2'b00);
        add(0, 2'b10, 1, 0, 0, 32'h100, 32'h20, 2'b01, 2'b00, 0, 0,      0, 2'b00);
        add(0, 2'b10, 1, 0, 0, 32'h100, 32'h20, 2'b10, 2'b00, 1, 32'h20, 1, 2'b00);
        add(0, 2'b00, 1, 1, 0, 32'h100, 32'h20, 2'b00, 2'b10, 0, 0,      0, 2'b11);
        // D: mem_ready low for five cycles holds the turn pointer
        add(1, 2'b10, 0, 0, 0, 32'h100, 32'h20, 2'b00, 2'b00, 0, 0,      0, 2'b00);
        for (int k = 0; k < 5; k++)
            add(0, 2'b10, 0, 0, 0, 32'h100, 32'h20, 2'b00, 2'b00, 0, 0,  0, 2'b00);
        add(0, 2'b10, 1, 0, 0, 32'h100, 32'h20, 2'b01, 2'b00, 0, 0,      0, 2'b00);
        add(0, 2'b10, 1, 0, 0, 32'h100, 32'h20, 2'b10, 2'b00, 1, 32'h20, 1, 2'b00);
        add(0, 2'b00, 1, 1, 0, 32'h100, 32'h20, 2'b00, 2'b10, 0, 0,      0, 2'b11);
        // E: reset while busy, stale mem_valid ignored, then normal port0 request
        add(1, 2'b00, 1, 0, 0,            32'h100, 32'h20, 2'b00, 2'b00, 0, 0,       0, 2'b00);
        add(0, 2'b01, 1, 0, 0,            32'h100, 32'h20, 2'b01, 2'b00, 1, 32'h100, 0, 2'b00);
        add(0, 2'b00, 1, 0, 0,            32'h100, 32'h20, 2'b00, 2'b00, 0, 0,       0, 2'b10);
        add(1, 2'b00, 1, 0, 0,            32'h100, 32'h20, 2'b00, 2'b00, 0, 0,       0, 2'b10);
        add(0, 2'b00, 1, 1, 32'hBAD0BAD0, 32'h100, 32'h20, 2'b01, 2'b00, 0, 0,       0, 2'b00);
        add(0, 2'b01, 1, 0, 0,            32'h100, 32'h20, 2'b10, 2'b00, 0, 0,       0, 2'b00);
        add(0, 2'b01, 1, 0, 0,            32'h100, 32'h20, 2'b01, 2'b00, 1, 32'h100, 0, 2'b00);
        add(0, 2'b00, 1, 1, 32'h600D600D, 32'h100, 32'h20, 2'b00, 2'b01, 0, 0,       0, 2'b10);
        // F: completion cycle with port1 enable is not an accept; accept follows
        add(1, 2'b00, 1, 0, 0,            32'h100, 32'h20, 2'b00, 2'b00, 0, 0,       0, 2'b00);
        add(0, 2'b01, 1, 0, 0,            32'h100, 32'h20, 2'b01, 2'b00, 1, 32'h100, 0, 2'b00);
        add(0, 2'b10, 1, 1, 32'hABCD0123, 32'h100, 32'h20, 2'b00, 2'b01, 0, 0,       0, 2'b10);
        add(0, 2'b10, 1, 0, 0,            32'h100, 32'h20, 2'b10, 2'b00, 1, 32'h20,  1, 2'b00);
        add(0, 2'b00, 1, 1, 0,            32'h100, 32'h20, 2'b00, 2'b10, 0, 0,       0, 2'b11);

        reset       = 1'b1;
        req_enable  = 2'b00;
        req_command = 2'b10;
        req_address = '0;
        req_wdata[0] = P0_WDATA;
        req_wdata[1] = P1_WDATA;
        req_wstrb[0] = P0_WSTRB;
        req_wstrb[1] = P1_WSTRB;
        mem_ready   = 1'b1;
        mem_valid   = 1'b0;
        mem_rdata   = '0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            reset          = vecs[i].rst;
            req_enable     = vecs[i].en;
            mem_ready      = vecs[i].mr;
            mem_valid      = vecs[i].mv;
            mem_rdata      = vecs[i].rdata;
            req_address[0] = vecs[i].a0;
            req_address[1] = vecs[i].a1;
            @(negedge clk);
            applied++;
            chk(i, "req_ready",   32'(req_ready),   32'(vecs[i].xr));
            chk(i, "req_valid",   32'(req_valid),   32'(vecs[i].xv));
            chk(i, "mem_enable",  32'(mem_enable),  32'(vecs[i].xm));
            chk(i, "mem_command", 32'(mem_command), 32'(vecs[i].xcmd));
            chk(i, "owner",       32'(owner),       32'(vecs[i].xown));
            if (vecs[i].xm) begin
                chk(i, "mem_address", mem_address, vecs[i].xaddr);
                chk(i, "mem_wdata", mem_wdata, vecs[i].xcmd ? P1_WDATA : P0_WDATA);
                chk(i, "mem_wstrb", 32'(mem_wstrb), 32'(vecs[i].xcmd ? P1_WSTRB : P0_WSTRB));
            end
            if (vecs[i].xv == 2'b01)
                chk(i, "req_rdata", req_rdata, vecs[i].rdata);
            if (!reset && mem_enable && mem_valid) begin
                miscompares++;
                $display("FAIL vec %0d protocol: mem_valid=1 in accept cycle, required 0", i);
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Shares the single memory port between two requesters: port 0 is the core controller (fetch, load and store) and port 1 is an auxiliary master (debug or DMA). Each requester sees the same ready/enable/valid handshake the controller already drives. The arbiter allows one outstanding transaction at a time, uses a round-robin turn pointer, and routes the response back to the owner. It sits between the controller/datapath and the memory.

Parameters:
ADDR_WIDTH, 32, address width of requesters and memory
DATA_WIDTH, 32, data width
STRB_WIDTH, DATA_WIDTH/8, byte write-strobe width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req_enable  in  2  per-requester transfer request; legal only in a cycle where that requester's req_ready=1
req_command  in  2  per-requester command, 0=read, 1=write
req_address  in  2xADDR_WIDTH  per-requester address
req_wdata  in  2xDATA_WIDTH  per-requester write data
req_wstrb  in  2xSTRB_WIDTH  per-requester byte strobes
req_ready  out  2  requester may assert enable this cycle
req_valid  out  2  response/completion pulse to the owner
req_rdata  out  DATA_WIDTH  read data, common to both; meaningful only with req_valid
mem_enable  out  1  downstream request
mem_command  out  1  downstream command
mem_address  out  ADDR_WIDTH  downstream address
mem_wdata  out  DATA_WIDTH  downstream write data
mem_wstrb  out  STRB_WIDTH  downstream strobes
mem_ready  in  1  memory can accept
mem_valid  in  1  memory completion pulse
mem_rdata  in  DATA_WIDTH  memory read data
owner  out  2  debug: bit1 = busy, bit0 = owning requester

Behaviour:
- State: idle, or busy with owner index. Also a 1-bit turn pointer.
- Reset values: idle, turn=0, owner=0, all req_ready=0, req_valid=0, mem_enable=0, mem_command=0.
- Idle state:
  - req_ready[i] = mem_ready & (turn==i).
  - req_ready[i] never depends on req_enable, so there is no combinational loop.
  - The other requester's ready is 0.
- Downstream forwarding: mem_enable = req_enable[turn] & req_ready[turn]. mem_command, mem_address, mem_wdata and mem_wstrb are a combinational mux of requester[turn].
- Accept: in a cycle with mem_enable=1 (mem_ready=1 is implied), the next state is busy with owner=turn.
- Park flip: in idle with mem_ready=1 and req_enable[turn]=0, turn toggles next cycle.
  - Worst-case grant wait is 1 cycle if the other side is idle, or 1 transaction plus 1 cycle if it is busy.
- No flip while mem_ready=0: turn holds.
- Busy state:
  - req_ready=00 and mem_enable=0.
  - mem_valid=1 gives req_valid[owner]=1 in the same cycle (combinational), req_rdata=mem_rdata. The next state is idle and turn = ~owner (fairness).
- mem_valid in the same cycle as accept is illegal: a response needs at least 1 cycle after accept. A bench assertion flags it.
- mem_valid while idle is ignored: req_valid stays 00. This covers stale responses after reset.
- Back-to-back: a completion cycle cannot also accept. The earliest new accept is the cycle after mem_valid.
- Reset mid-transaction: returns to idle and drops the outstanding response. The memory is reset by the same reset.
- Only a read returns meaningful rdata. A write completes with req_valid only, and rdata is don't-care.
- req_valid is exactly one cycle per accepted transaction, to the accepting requester only.

Decomposition:
- Shared header memory.h holds:
  - MEM_READ=0 and MEM_WRITE=1 command constants.
  - The requester index constants REQ_CORE=0 and REQ_AUX=1.
- The controller's existing memory_command encoding moves to these constants.
- No sub-module. The FSM, turn pointer and muxes live in one file.

Test Plan:
- Reset, then port0 read at 0x100, memory answers after 3 cycles with 0xDEADBEEF:
  - req_ready=01 in the first idle cycle.
  - mem_address=0x100 and mem_command=0 on accept.
  - req_valid=01 with rdata=0xDEADBEEF exactly on the mem_valid cycle.
- Both ports continuously request, port0 read 0x10 and port1 write 0x20 data 0x55 strb 0001:
  - Grants alternate 0,1,0,1.
  - Port1's mem_wdata=0x55 and mem_wstrb=0001 are seen downstream.
- Port0 idle, port1 requests at reset release:
  - Cycle 0 has turn=0 with no enable, so turn flips.
  - Cycle 1 gives req_ready=10 and port1 is accepted.
- mem_ready=0 for 5 cycles while port1 requests:
  - req_ready=00 and turn stays 0 throughout.
  - Once mem_ready=1, the flip proceeds as above.
- Reset asserted while busy, then a late mem_valid:
  - owner=00, req_valid=00.
  - The next port0 request is accepted normally.
- Busy, mem_valid and port1 enable in the same cycle:
  - Port1 is not accepted that cycle (req_ready=00).
  - Port1 is accepted the following cycle because turn=1.
